// File: rtl/flags_unit_if.sv
// Bus between the execute stage and the NZCV flags writer.
// master: execute-stage side (drives the ALU op, gating and save/restore, reads flags).
// slave : flags_unit side (consumes the op, drives Flags, SavedFlags,
//         FlagsChanged and FlagWrCount).
interface flags_unit_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
);
  logic             ValidE;
  logic             StallE;
  logic             FlushE;
  logic             CondExE;
  logic [1:0]       FlagWriteE;
  logic [1:0]       ALUControlE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             SaveFlags;
  logic             RestoreFlags;
  logic [3:0]       Flags;
  logic [3:0]       SavedFlags;
  logic             FlagsChanged;
  logic [CNT_W-1:0] FlagWrCount;

  modport master (
    output ValidE, StallE, FlushE, CondExE, FlagWriteE, ALUControlE,
           SrcAE, SrcBE, SaveFlags, RestoreFlags,
    input  Flags, SavedFlags, FlagsChanged, FlagWrCount
  );

  modport slave (
    input  ValidE, StallE, FlushE, CondExE, FlagWriteE, ALUControlE,
           SrcAE, SrcBE, SaveFlags, RestoreFlags,
    output Flags, SavedFlags, FlagsChanged, FlagWrCount
  );
endinterface

// File: rtl/flags_unit.sv
// NZCV condition-flags writer.
// Computes candidate N/Z/C/V from the execute-stage ALU op and commits them into
// the architectural flags register under per-field enables and pipeline gating.
// Also holds a shadow flags register for exception save/restore and a saturating
// count of committed flag writes.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - flags_unit_if.slave: ALU operands/op, enables, save/restore in;
//           Flags, SavedFlags, FlagsChanged, FlagWrCount out (all registered)
module flags_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic         clk,
  input  logic         reset,
  flags_unit_if.slave  bus
);

  localparam int unsigned SUM_W = WIDTH + 1;
  localparam int unsigned MSB   = WIDTH - 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_ORR = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [3:0]       flags_q;
  logic [3:0]       saved_q;
  logic             changed_q;
  logic [CNT_W-1:0] count_q;

  logic             is_sub;
  logic             is_arith;
  logic [WIDTH-1:0] b_eff;
  logic [SUM_W-1:0] sum;
  logic [WIDTH-1:0] result;
  logic             cand_n;
  logic             cand_z;
  logic             cand_c;
  logic             cand_v;
  logic             wr;
  logic             wr_nz;
  logic             wr_cv;
  logic             alu_wr;
  logic [3:0]       flags_next;

  // ALU result and candidate flags; SUB reuses the adder as A + ~B + 1
  always_comb begin
    is_sub   = (bus.ALUControlE == OP_SUB);
    is_arith = (bus.ALUControlE == OP_ADD) || is_sub;
    b_eff    = is_sub ? ~bus.SrcBE : bus.SrcBE;
    sum      = {1'b0, bus.SrcAE} + {1'b0, b_eff} + SUM_W'(is_sub);
    result   = sum[WIDTH-1:0];
    case (bus.ALUControlE)
      OP_AND:  result = bus.SrcAE & bus.SrcBE;
      OP_ORR:  result = bus.SrcAE | bus.SrcBE;
      default: result = sum[WIDTH-1:0];
    endcase
    cand_n = result[MSB];
    cand_z = (result == '0);
    cand_c = sum[WIDTH];
    cand_v = (bus.SrcAE[MSB] == b_eff[MSB]) && (result[MSB] != bus.SrcAE[MSB]);
  end

  // Commit gating and next flags value; restore overrides any ALU write
  always_comb begin
    wr     = bus.ValidE && bus.CondExE && !bus.StallE && !bus.FlushE;
    wr_nz  = wr && bus.FlagWriteE[1];
    wr_cv  = wr && bus.FlagWriteE[0] && is_arith;
    alu_wr = (wr_nz || wr_cv) && !bus.RestoreFlags;
    flags_next = flags_q;
    if (bus.RestoreFlags) begin
      flags_next = saved_q;
    end else begin
      if (wr_nz) flags_next[3:2] = {cand_n, cand_z};
      if (wr_cv) flags_next[1:0] = {cand_c, cand_v};
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q   <= 4'b0000;
      saved_q   <= 4'b0000;
      changed_q <= 1'b0;
      count_q   <= '0;
    end else begin
      flags_q   <= flags_next;
      changed_q <= (flags_next != flags_q);
      // save captures pre-edge flags; a concurrent restore keeps the shadow intact
      if (bus.SaveFlags && !bus.RestoreFlags) saved_q <= flags_q;
      if (alu_wr && (count_q != CNT_MAX)) count_q <= count_q + CNT_W'(1);
    end
  end

  assign bus.Flags        = flags_q;
  assign bus.SavedFlags   = saved_q;
  assign bus.FlagsChanged = changed_q;
  assign bus.FlagWrCount  = count_q;

endmodule

// File: tb/tb_flags_unit.sv
// Self-checking bench for flags_unit: directed scenarios plus randomized traffic,
// checked against a behavioural NZCV model using wide integer arithmetic.
// A second instance with a 2-bit counter receives identical stimulus.
module tb_flags_unit;

  logic clk;
  logic reset;

  flags_unit_if #(.WIDTH(32), .CNT_W(16)) bus  ();
  flags_unit_if #(.WIDTH(32), .CNT_W(2))  bus2 ();

  flags_unit #(.WIDTH(32), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
  flags_unit #(.WIDTH(32), .CNT_W(2))  dut2 (.clk(clk), .reset(reset), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference state
  logic [3:0] m_flags;
  logic [3:0] m_saved;
  logic       m_changed;
  int         m_count;
  int         m_count2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Architectural rules evaluated with 64-bit integer arithmetic
  task automatic model_edge(input logic rst, input logic valid, input logic stall,
                            input logic flush, input logic cond, input logic [1:0] fw,
                            input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic save, input logic restore);
    longint ua, ub, r, sa, sb, sr;
    logic [31:0] res;
    logic n, z, c, v, wr, arith, alu;
    logic [3:0] nxt;
    if (rst) begin
      m_flags = 4'b0; m_saved = 4'b0; m_changed = 1'b0; m_count = 0; m_count2 = 0;
      return;
    end
    ua = longint'(a); ub = longint'(b);
    sa = $signed(a);  sb = $signed(b);
    c = 1'b0; v = 1'b0; sr = 0;
    case (op)
      2'd0: begin r = ua + ub; c = (r >= 64'h1_0000_0000); sr = sa + sb; end
      2'd1: begin r = ua - ub; c = (ua >= ub);             sr = sa - sb; end
      2'd2: r = longint'(a & b);
      default: r = longint'(a | b);
    endcase
    res = r[31:0];
    n = res[31];
    z = (res == 32'd0);
    v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    arith = (op < 2'd2);
    wr = valid && cond && !stall && !flush;
    nxt = m_flags;
    alu = 1'b0;
    if (restore) nxt = m_saved;
    else begin
      if (wr && fw[1]) begin nxt[3] = n; nxt[2] = z; alu = 1'b1; end
      if (wr && fw[0] && arith) begin nxt[1] = c; nxt[0] = v; alu = 1'b1; end
    end
    m_changed = (nxt != m_flags);
    if (save && !restore) m_saved = m_flags;
    m_flags = nxt;
    if (alu) begin
      if (m_count < 65535) m_count++;
      if (m_count2 < 3) m_count2++;
    end
  endtask

  // Apply one cycle of stimulus to both DUTs, advance the model, compare outputs
  task automatic step(input logic rst, input logic valid, input logic stall,
                      input logic flush, input logic cond, input logic [1:0] fw,
                      input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic save, input logic restore);
    reset = rst;
    bus.ValidE = valid;  bus.StallE = stall;  bus.FlushE = flush;  bus.CondExE = cond;
    bus.FlagWriteE = fw; bus.ALUControlE = op; bus.SrcAE = a;      bus.SrcBE = b;
    bus.SaveFlags = save; bus.RestoreFlags = restore;
    bus2.ValidE = valid;  bus2.StallE = stall;  bus2.FlushE = flush;  bus2.CondExE = cond;
    bus2.FlagWriteE = fw; bus2.ALUControlE = op; bus2.SrcAE = a;      bus2.SrcBE = b;
    bus2.SaveFlags = save; bus2.RestoreFlags = restore;
    @(posedge clk);
    #1;
    model_edge(rst, valid, stall, flush, cond, fw, op, a, b, save, restore);
    check("flags",   32'(bus.Flags),        32'(m_flags));
    check("saved",   32'(bus.SavedFlags),   32'(m_saved));
    check("changed", 32'(bus.FlagsChanged), 32'(m_changed));
    check("count",   32'(bus.FlagWrCount),  32'(m_count));
    check("count2",  32'(bus2.FlagWrCount), 32'(m_count2));
    check("flags2",  32'(bus2.Flags),       32'(m_flags));
  endtask

  // Committed instruction with all gating open
  task automatic op_commit(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, op, a, b, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rst_flags", 32'(bus.Flags), 32'h0);
    check("rst_count", 32'(bus.FlagWrCount), 32'h0);

    op_commit(2'b01, 32'd5, 32'd5);
    check("sub_eq_flags", 32'(bus.Flags), 32'h6);
    check("sub_eq_chg",   32'(bus.FlagsChanged), 32'h1);
    check("sub_eq_cnt",   32'(bus.FlagWrCount), 32'h1);

    op_commit(2'b00, 32'h7FFF_FFFF, 32'd1);
    check("add_ovf", 32'(bus.Flags), 32'h9);
    op_commit(2'b00, 32'hFFFF_FFFF, 32'd1);
    check("add_wrap", 32'(bus.Flags), 32'h6);
    op_commit(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    check("and_keep_cv", 32'(bus.Flags), 32'hA);

    // gated-off attempts at SUB 3-5
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    check("cond_fail_chg", 32'(bus.FlagsChanged), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 2'b11, 2'b01, 32'd3, 32'd5, 1'b0, 1'b0);
    check("stall_hold", 32'(bus.Flags), 32'hA);
    op_commit(2'b01, 32'd3, 32'd5);
    check("stall_release", 32'(bus.Flags), 32'h8);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0);

    // save with ALU write, then restore with a dropped ALU write
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b00, 32'd1, 32'd1, 1'b1, 1'b0);
    check("save_old", 32'(bus.SavedFlags), 32'h8);
    check("save_new", 32'(bus.Flags), 32'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 32'd1, 32'd1, 1'b0, 1'b1);
    check("restore_flags", 32'(bus.Flags), 32'h8);
    check("restore_chg",   32'(bus.FlagsChanged), 32'h1);
    check("sat_count2",    32'(bus2.FlagWrCount), 32'h3);

    // reset in the middle of a write
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11, 2'b01, 32'd3, 32'd5, 1'b1, 1'b0);
    check("rst_mid_flags", 32'(bus.Flags), 32'h0);
    check("rst_mid_saved", 32'(bus.SavedFlags), 32'h0);

    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 9) != 0,
           $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 4) != 0,
           2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)),
           pick_operand(), pick_operand(),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 9) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
